// File: rtl/acl_txbuf_ctrl.sv
// Per-LT_ADDR ping-pong ACL TX payload buffer manager: picks new/old/zero-length payload
// at header start, releases ACKed buffers to the MCU and tracks MCU loads and flushes.
module acl_txbuf_ctrl #(
    parameter int NLT  = 8,
    parameter int LENW = 10
) (
    input  logic              clk_6M,
    input  logic              rstz,
    input  logic              connsnewmaster,
    input  logic              connsnewslave,
    input  logic              pk_encode,
    input  logic              header_st_p,
    input  logic [2:0]        txpk_lt_addr,
    input  logic              sendnewpy,
    input  logic              sendoldpy,
    input  logic              send0py,
    input  logic              regi_txload_p,
    input  logic [2:0]        regi_txload_ltaddr,
    input  logic [LENW-1:0]   regi_txload_len,
    input  logic              regi_flush_p,
    input  logic [2:0]        regi_flush_ltaddr,
    output logic              txpy_valid,
    output logic              txpy_bufsel,
    output logic [2:0]        txpy_ltaddr,
    output logic [LENW-1:0]   txpy_len,
    output logic              txdone_p,
    output logic [2:0]        txdone_ltaddr,
    output logic              txdone_buf,
    output logic              txdone_flushed,
    output logic              load_err_p,
    output logic [2*NLT-1:0]  txbuf_status
);

    function automatic logic lt_in_range(input logic [2:0] lt);
        return (int'(lt) < NLT);
    endfunction

    // Per-link buffer state
    logic [NLT-1:0]  wptr_q, wptr_d;
    logic [NLT-1:0]  rptr_q, rptr_d;
    logic [NLT-1:0]  inflight_q, inflight_d;
    logic [1:0]      valid_q [NLT];
    logic [1:0]      valid_d [NLT];
    logic [LENW-1:0] len_q [NLT][2];
    logic [LENW-1:0] len_d [NLT][2];

    // Registered outputs
    logic            txpy_valid_q, txpy_valid_d;
    logic            txpy_bufsel_q, txpy_bufsel_d;
    logic [2:0]      txpy_ltaddr_q, txpy_ltaddr_d;
    logic [LENW-1:0] txpy_len_q, txpy_len_d;
    logic            txdone_p_q, txdone_p_d;
    logic [2:0]      txdone_ltaddr_q, txdone_ltaddr_d;
    logic            txdone_buf_q, txdone_buf_d;
    logic            txdone_flushed_q, txdone_flushed_d;
    logic            load_err_p_q, load_err_p_d;

    logic [2:0]      dec_lt_s;
    logic [2:0]      ld_lt_s;
    logic [2:0]      fl_lt_s;
    logic            dec_s;
    logic            ld_s;
    logic            fl_s;
    logic            conn_s;
    logic            rptr_s;
    logic            inflight_s;
    logic            cand_s;

    assign dec_lt_s   = txpk_lt_addr;
    assign ld_lt_s    = regi_txload_ltaddr;
    assign fl_lt_s    = regi_flush_ltaddr;
    assign conn_s     = connsnewmaster | connsnewslave;
    assign dec_s      = header_st_p & pk_encode & lt_in_range(dec_lt_s);
    assign ld_s       = regi_txload_p & lt_in_range(ld_lt_s);
    assign fl_s       = regi_flush_p & lt_in_range(fl_lt_s);
    assign rptr_s     = rptr_q[dec_lt_s];
    assign inflight_s = inflight_q[dec_lt_s];
    // A new payload after an ACK comes from the other buffer, otherwise from the read pointer
    assign cand_s     = inflight_s ? ~rptr_s : rptr_s;

    // Next-state and next-output computation for decision, load and flush
    always_comb begin
        wptr_d           = wptr_q;
        rptr_d           = rptr_q;
        inflight_d       = inflight_q;
        valid_d          = valid_q;
        len_d            = len_q;
        txpy_valid_d     = txpy_valid_q;
        txpy_bufsel_d    = txpy_bufsel_q;
        txpy_ltaddr_d    = txpy_ltaddr_q;
        txpy_len_d       = txpy_len_q;
        txdone_p_d       = 1'b0;
        txdone_ltaddr_d  = txdone_ltaddr_q;
        txdone_buf_d     = txdone_buf_q;
        txdone_flushed_d = txdone_flushed_q;
        load_err_p_d     = 1'b0;

        if (conn_s) begin
            for (int i = 0; i < NLT; i++) begin
                valid_d[i]  = 2'b00;
                len_d[i][0] = {LENW{1'b0}};
                len_d[i][1] = {LENW{1'b0}};
            end
            wptr_d           = {NLT{1'b0}};
            rptr_d           = {NLT{1'b0}};
            inflight_d       = {NLT{1'b0}};
            txpy_valid_d     = 1'b0;
            txpy_bufsel_d    = 1'b0;
            txpy_ltaddr_d    = 3'd0;
            txpy_len_d       = {LENW{1'b0}};
            txdone_ltaddr_d  = 3'd0;
            txdone_buf_d     = 1'b0;
            txdone_flushed_d = 1'b0;
        end else begin
            if (dec_s) begin
                txpy_ltaddr_d = dec_lt_s;
                if (fl_s && (fl_lt_s == dec_lt_s)) begin
                    txpy_valid_d  = 1'b0;
                    txpy_bufsel_d = 1'b0;
                    txpy_len_d    = {LENW{1'b0}};
                end else if (send0py) begin
                    if (inflight_s) begin
                        valid_d[dec_lt_s][rptr_s] = 1'b0;
                        rptr_d[dec_lt_s]          = ~rptr_s;
                        inflight_d[dec_lt_s]      = 1'b0;
                        txdone_p_d                = 1'b1;
                        txdone_ltaddr_d           = dec_lt_s;
                        txdone_buf_d              = rptr_s;
                        txdone_flushed_d          = 1'b1;
                    end else begin
                        txdone_p_d = 1'b0;
                    end
                    txpy_valid_d  = 1'b1;
                    txpy_bufsel_d = 1'b0;
                    txpy_len_d    = {LENW{1'b0}};
                end else if (sendoldpy) begin
                    if (inflight_s) begin
                        txpy_valid_d  = 1'b1;
                        txpy_bufsel_d = rptr_s;
                        txpy_len_d    = len_q[dec_lt_s][rptr_s];
                    end else begin
                        txpy_valid_d  = 1'b0;
                        txpy_bufsel_d = 1'b0;
                        txpy_len_d    = {LENW{1'b0}};
                    end
                end else if (sendnewpy) begin
                    if (inflight_s) begin
                        valid_d[dec_lt_s][rptr_s] = 1'b0;
                        rptr_d[dec_lt_s]          = ~rptr_s;
                        txdone_p_d                = 1'b1;
                        txdone_ltaddr_d           = dec_lt_s;
                        txdone_buf_d              = rptr_s;
                        txdone_flushed_d          = 1'b0;
                    end else begin
                        txdone_p_d = 1'b0;
                    end
                    if (valid_q[dec_lt_s][cand_s]) begin
                        txpy_valid_d         = 1'b1;
                        txpy_bufsel_d        = cand_s;
                        txpy_len_d           = len_q[dec_lt_s][cand_s];
                        inflight_d[dec_lt_s] = 1'b1;
                    end else begin
                        txpy_valid_d         = 1'b0;
                        txpy_bufsel_d        = 1'b0;
                        txpy_len_d           = {LENW{1'b0}};
                        inflight_d[dec_lt_s] = 1'b0;
                    end
                end else begin
                    txpy_valid_d  = 1'b0;
                    txpy_bufsel_d = 1'b0;
                    txpy_len_d    = {LENW{1'b0}};
                end
            end else begin
                txpy_valid_d = txpy_valid_q;
            end

            // Load checks pre-cycle valid, so a buffer released this cycle still refuses it
            if (ld_s) begin
                if (valid_q[ld_lt_s][wptr_q[ld_lt_s]]) begin
                    load_err_p_d = 1'b1;
                end else begin
                    valid_d[ld_lt_s][wptr_q[ld_lt_s]] = 1'b1;
                    len_d[ld_lt_s][wptr_q[ld_lt_s]]   = regi_txload_len;
                    wptr_d[ld_lt_s]                   = ~wptr_q[ld_lt_s];
                end
            end else begin
                load_err_p_d = 1'b0;
            end

            if (fl_s) begin
                valid_d[fl_lt_s]    = 2'b00;
                inflight_d[fl_lt_s] = 1'b0;
                wptr_d[fl_lt_s]     = 1'b0;
                rptr_d[fl_lt_s]     = 1'b0;
            end else begin
                inflight_d[fl_lt_s] = inflight_d[fl_lt_s];
            end
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            for (int i = 0; i < NLT; i++) begin
                valid_q[i]  <= 2'b00;
                len_q[i][0] <= {LENW{1'b0}};
                len_q[i][1] <= {LENW{1'b0}};
            end
            wptr_q           <= {NLT{1'b0}};
            rptr_q           <= {NLT{1'b0}};
            inflight_q       <= {NLT{1'b0}};
            txpy_valid_q     <= 1'b0;
            txpy_bufsel_q    <= 1'b0;
            txpy_ltaddr_q    <= 3'd0;
            txpy_len_q       <= {LENW{1'b0}};
            txdone_p_q       <= 1'b0;
            txdone_ltaddr_q  <= 3'd0;
            txdone_buf_q     <= 1'b0;
            txdone_flushed_q <= 1'b0;
            load_err_p_q     <= 1'b0;
        end else begin
            valid_q          <= valid_d;
            len_q            <= len_d;
            wptr_q           <= wptr_d;
            rptr_q           <= rptr_d;
            inflight_q       <= inflight_d;
            txpy_valid_q     <= txpy_valid_d;
            txpy_bufsel_q    <= txpy_bufsel_d;
            txpy_ltaddr_q    <= txpy_ltaddr_d;
            txpy_len_q       <= txpy_len_d;
            txdone_p_q       <= txdone_p_d;
            txdone_ltaddr_q  <= txdone_ltaddr_d;
            txdone_buf_q     <= txdone_buf_d;
            txdone_flushed_q <= txdone_flushed_d;
            load_err_p_q     <= load_err_p_d;
        end
    end

    for (genvar g = 0; g < NLT; g++) begin : g_status
        assign txbuf_status[2*g +: 2] = valid_q[g];
    end

    assign txpy_valid     = txpy_valid_q;
    assign txpy_bufsel    = txpy_bufsel_q;
    assign txpy_ltaddr    = txpy_ltaddr_q;
    assign txpy_len       = txpy_len_q;
    assign txdone_p       = txdone_p_q;
    assign txdone_ltaddr  = txdone_ltaddr_q;
    assign txdone_buf     = txdone_buf_q;
    assign txdone_flushed = txdone_flushed_q;
    assign load_err_p     = load_err_p_q;

endmodule

// File: tb/tb_acl_txbuf_ctrl.sv
// Directed bench for acl_txbuf_ctrl: load, ARQ decisions, flush, connsnew and reset scenarios.
module tb_acl_txbuf_ctrl;

    localparam int NLT  = 8;
    localparam int LENW = 10;

    logic              clk_6M = 1'b0;
    logic              rstz;
    logic              connsnewmaster;
    logic              connsnewslave;
    logic              pk_encode;
    logic              header_st_p;
    logic [2:0]        txpk_lt_addr;
    logic              sendnewpy;
    logic              sendoldpy;
    logic              send0py;
    logic              regi_txload_p;
    logic [2:0]        regi_txload_ltaddr;
    logic [LENW-1:0]   regi_txload_len;
    logic              regi_flush_p;
    logic [2:0]        regi_flush_ltaddr;
    logic              txpy_valid;
    logic              txpy_bufsel;
    logic [2:0]        txpy_ltaddr;
    logic [LENW-1:0]   txpy_len;
    logic              txdone_p;
    logic [2:0]        txdone_ltaddr;
    logic              txdone_buf;
    logic              txdone_flushed;
    logic              load_err_p;
    logic [2*NLT-1:0]  txbuf_status;

    int errors = 0;
    int checks = 0;

    acl_txbuf_ctrl #(.NLT(NLT), .LENW(LENW)) dut (
        .clk_6M             (clk_6M),
        .rstz               (rstz),
        .connsnewmaster     (connsnewmaster),
        .connsnewslave      (connsnewslave),
        .pk_encode          (pk_encode),
        .header_st_p        (header_st_p),
        .txpk_lt_addr       (txpk_lt_addr),
        .sendnewpy          (sendnewpy),
        .sendoldpy          (sendoldpy),
        .send0py            (send0py),
        .regi_txload_p      (regi_txload_p),
        .regi_txload_ltaddr (regi_txload_ltaddr),
        .regi_txload_len    (regi_txload_len),
        .regi_flush_p       (regi_flush_p),
        .regi_flush_ltaddr  (regi_flush_ltaddr),
        .txpy_valid         (txpy_valid),
        .txpy_bufsel        (txpy_bufsel),
        .txpy_ltaddr        (txpy_ltaddr),
        .txpy_len           (txpy_len),
        .txdone_p           (txdone_p),
        .txdone_ltaddr      (txdone_ltaddr),
        .txdone_buf         (txdone_buf),
        .txdone_flushed     (txdone_flushed),
        .load_err_p         (load_err_p),
        .txbuf_status       (txbuf_status)
    );

    always #5 clk_6M = ~clk_6M;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic clear_pulses();
        header_st_p   = 1'b0;
        pk_encode     = 1'b0;
        sendnewpy     = 1'b0;
        sendoldpy     = 1'b0;
        send0py       = 1'b0;
        regi_txload_p = 1'b0;
        regi_flush_p  = 1'b0;
        connsnewslave = 1'b0;
        connsnewmaster = 1'b0;
    endtask

    task automatic set_load(input logic [2:0] lt, input logic [LENW-1:0] len);
        regi_txload_p      = 1'b1;
        regi_txload_ltaddr = lt;
        regi_txload_len    = len;
    endtask

    task automatic set_dec(input logic [2:0] lt, input logic nw, input logic od, input logic zr);
        pk_encode    = 1'b1;
        header_st_p  = 1'b1;
        txpk_lt_addr = lt;
        sendnewpy    = nw;
        sendoldpy    = od;
        send0py      = zr;
    endtask

    task automatic do_load(input logic [2:0] lt, input logic [LENW-1:0] len);
        set_load(lt, len);
        tick();
        clear_pulses();
    endtask

    task automatic do_dec(input logic [2:0] lt, input logic nw, input logic od, input logic zr);
        set_dec(lt, nw, od, zr);
        tick();
        clear_pulses();
    endtask

    initial begin
        rstz = 1'b0;
        txpk_lt_addr = 3'd0;
        regi_txload_ltaddr = 3'd0;
        regi_txload_len = 10'd0;
        regi_flush_ltaddr = 3'd0;
        clear_pulses();
        repeat (3) tick();
        check_eq("rst_valid", 32'(txpy_valid), 32'd0);
        check_eq("rst_len", 32'(txpy_len), 32'd0);
        check_eq("rst_status", 32'(txbuf_status), 32'd0);
        check_eq("rst_done", 32'(txdone_p), 32'd0);
        rstz = 1'b1;
        tick();

        // T1
        do_load(3'd1, 10'd27);
        check_eq("t1_lderr", 32'(load_err_p), 32'd0);
        check_eq("t1_status", 32'(txbuf_status[3:2]), 32'd1);
        do_dec(3'd1, 1'b1, 1'b0, 1'b0);
        check_eq("t1_valid", 32'(txpy_valid), 32'd1);
        check_eq("t1_bufsel", 32'(txpy_bufsel), 32'd0);
        check_eq("t1_len", 32'(txpy_len), 32'd27);
        check_eq("t1_lt", 32'(txpy_ltaddr), 32'd1);
        check_eq("t1_done", 32'(txdone_p), 32'd0);

        // T2
        for (int i = 0; i < 3; i++) begin
            do_dec(3'd1, 1'b0, 1'b1, 1'b0);
            check_eq("t2_old_valid", 32'(txpy_valid), 32'd1);
            check_eq("t2_old_bufsel", 32'(txpy_bufsel), 32'd0);
            check_eq("t2_old_len", 32'(txpy_len), 32'd27);
        end
        do_load(3'd1, 10'd100);
        check_eq("t2_status_ld", 32'(txbuf_status[3:2]), 32'd3);
        do_dec(3'd1, 1'b1, 1'b0, 1'b0);
        check_eq("t2_done", 32'(txdone_p), 32'd1);
        check_eq("t2_done_lt", 32'(txdone_ltaddr), 32'd1);
        check_eq("t2_done_buf", 32'(txdone_buf), 32'd0);
        check_eq("t2_done_fl", 32'(txdone_flushed), 32'd0);
        check_eq("t2_bufsel", 32'(txpy_bufsel), 32'd1);
        check_eq("t2_len", 32'(txpy_len), 32'd100);
        check_eq("t2_status", 32'(txbuf_status[3:2]), 32'd2);
        tick();
        check_eq("t2_done_pulse", 32'(txdone_p), 32'd0);
        check_eq("t2_hold_len", 32'(txpy_len), 32'd100);

        // T3
        do_load(3'd2, 10'd5);
        do_load(3'd2, 10'd6);
        check_eq("t3_status2", 32'(txbuf_status[5:4]), 32'd3);
        do_load(3'd2, 10'd7);
        check_eq("t3_lderr", 32'(load_err_p), 32'd1);
        check_eq("t3_status3", 32'(txbuf_status[5:4]), 32'd3);
        tick();
        check_eq("t3_lderr_pulse", 32'(load_err_p), 32'd0);

        // T4
        do_load(3'd3, 10'd50);
        do_dec(3'd3, 1'b1, 1'b0, 1'b0);
        check_eq("t4_len50", 32'(txpy_len), 32'd50);
        do_dec(3'd3, 1'b1, 1'b1, 1'b1);
        check_eq("t4_valid", 32'(txpy_valid), 32'd1);
        check_eq("t4_len0", 32'(txpy_len), 32'd0);
        check_eq("t4_done", 32'(txdone_p), 32'd1);
        check_eq("t4_done_fl", 32'(txdone_flushed), 32'd1);
        check_eq("t4_done_lt", 32'(txdone_ltaddr), 32'd3);
        check_eq("t4_status", 32'(txbuf_status[7:6]), 32'd0);
        do_dec(3'd3, 1'b1, 1'b0, 1'b0);
        check_eq("t4_nodata", 32'(txpy_valid), 32'd0);
        check_eq("t4_nodone", 32'(txdone_p), 32'd0);

        // T5: flush lt1 in the same cycle as its decision
        set_dec(3'd1, 1'b1, 1'b0, 1'b0);
        regi_flush_p = 1'b1;
        regi_flush_ltaddr = 3'd1;
        tick();
        clear_pulses();
        check_eq("t5_valid", 32'(txpy_valid), 32'd0);
        check_eq("t5_status", 32'(txbuf_status[3:2]), 32'd0);
        check_eq("t5_nodone", 32'(txdone_p), 32'd0);

        // Load onto a buffer released in the same cycle is refused
        do_load(3'd4, 10'd10);
        do_load(3'd4, 10'd11);
        do_dec(3'd4, 1'b1, 1'b0, 1'b0);
        check_eq("ld_dec_len10", 32'(txpy_len), 32'd10);
        set_dec(3'd4, 1'b1, 1'b0, 1'b0);
        set_load(3'd4, 10'd12);
        tick();
        clear_pulses();
        check_eq("ld_dec_err", 32'(load_err_p), 32'd1);
        check_eq("ld_dec_done_buf", 32'(txdone_buf), 32'd0);
        check_eq("ld_dec_bufsel", 32'(txpy_bufsel), 32'd1);
        check_eq("ld_dec_len", 32'(txpy_len), 32'd11);
        check_eq("ld_dec_status", 32'(txbuf_status[9:8]), 32'd2);

        // T6: connsnew with pending load on a full link
        check_eq("t6_pre_status", 32'(txbuf_status), 32'h0230);
        connsnewslave = 1'b1;
        set_load(3'd2, 10'd9);
        tick();
        clear_pulses();
        check_eq("t6_status", 32'(txbuf_status), 32'd0);
        check_eq("t6_lderr", 32'(load_err_p), 32'd0);
        check_eq("t6_valid", 32'(txpy_valid), 32'd0);

        do_load(3'd5, 10'd33);
        do_dec(3'd5, 1'b1, 1'b0, 1'b0);
        check_eq("t6_pre_len", 32'(txpy_len), 32'd33);
        #2;
        rstz = 1'b0;
        #1;
        check_eq("t6_rst_valid", 32'(txpy_valid), 32'd0);
        check_eq("t6_rst_len", 32'(txpy_len), 32'd0);
        check_eq("t6_rst_lt", 32'(txpy_ltaddr), 32'd0);
        check_eq("t6_rst_status", 32'(txbuf_status), 32'd0);
        #10;
        rstz = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
